// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit execute-stage ALU: widths, opcodes and
// the barrel-shifter mode encoding.
// Optional feature macro: ALU_SLTU_EN (opcode 11 performs unsigned set-less-than).
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 5'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 5'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 5'd7;
    localparam logic [OP_W-1:0] OP_ROTL = 5'd8;
    localparam logic [OP_W-1:0] OP_ROTR = 5'd9;
    localparam logic [OP_W-1:0] OP_SLT  = 5'd10;
    localparam logic [OP_W-1:0] OP_SLTU = 5'd11;

    // Barrel-shifter mode select
    localparam logic [2:0] SH_SLL  = 3'd0;
    localparam logic [2:0] SH_SRL  = 3'd1;
    localparam logic [2:0] SH_SRA  = 3'd2;
    localparam logic [2:0] SH_ROTL = 3'd3;
    localparam logic [2:0] SH_ROTR = 3'd4;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: logical/arithmetic shifts and rotates.
// Rotates rely on a shift by 32 yielding zero, so shamt=0 returns A unchanged.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  A,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         mode,
    output logic [DATA_W-1:0]  y
);

    logic [5:0] w_inv_amt;

    assign w_inv_amt = 6'd32 - {1'b0, shamt};

    // Select the shift/rotate flavour for the current mode
    always_comb begin
        y = 32'd0;
        case (mode)
            SH_SLL:  y = A << shamt;
            SH_SRL:  y = A >> shamt;
            SH_SRA:  y = $unsigned($signed(A) >>> shamt);
            SH_ROTL: y = (A << shamt) | (A >> w_inv_amt);
            SH_ROTR: y = (A >> shamt) | (A << w_inv_amt);
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 32-bit execute-stage ALU with a single registered output stage (latency 1).
// Optional feature macro: ALU_SLTU_EN enables opcode 11 (unsigned SLT);
// without it opcode 11 is treated like every other unused opcode.
module alu
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  A,
    input  logic [DATA_W-1:0]  B,
    input  logic               cin,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [OP_W-1:0]    opcode,
    output logic [DATA_W-1:0]  result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero
);

    logic [DATA_W:0]   w_add_sum;
    logic [DATA_W:0]   w_sub_sum;
    logic [2:0]        w_sh_mode;
    logic [DATA_W-1:0] w_sh_out;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_ovf;

    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic              r_ovf;
    logic              r_zero;

    // SUB is A + ~B + 1 so bit 32 is the "no borrow" flag
    assign w_add_sum = {1'b0, A} + {1'b0, B} + {32'd0, cin};
    assign w_sub_sum = {1'b0, A} + {1'b0, ~B} + 33'd1;

    // Map shift/rotate opcodes onto the shifter mode
    always_comb begin
        w_sh_mode = SH_SLL;
        case (opcode)
            OP_SLL:  w_sh_mode = SH_SLL;
            OP_SRL:  w_sh_mode = SH_SRL;
            OP_SRA:  w_sh_mode = SH_SRA;
            OP_ROTL: w_sh_mode = SH_ROTL;
            OP_ROTR: w_sh_mode = SH_ROTR;
            default: w_sh_mode = SH_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .A     (A),
        .shamt (shamt),
        .mode  (w_sh_mode),
        .y     (w_sh_out)
    );

    // Next result and flags; flags stay 0 except for ADD/SUB
    always_comb begin
        w_result = 32'd0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_result = w_add_sum[DATA_W-1:0];
                w_carry  = w_add_sum[DATA_W];
                w_ovf    = (A[31] & B[31] & ~w_add_sum[31]) |
                           (~A[31] & ~B[31] & w_add_sum[31]);
            end
            OP_SUB: begin
                w_result = w_sub_sum[DATA_W-1:0];
                w_carry  = w_sub_sum[DATA_W];
                w_ovf    = (A[31] & ~B[31] & ~w_sub_sum[31]) |
                           (~A[31] & B[31] & w_sub_sum[31]);
            end
            OP_AND:  w_result = A & B;
            OP_OR:   w_result = A | B;
            OP_XOR:  w_result = A ^ B;
            OP_SLL, OP_SRL, OP_SRA, OP_ROTL, OP_ROTR: w_result = w_sh_out;
            OP_SLT:  w_result = {31'd0, ($signed(A) < $signed(B))};
`ifdef ALU_SLTU_EN
            OP_SLTU: w_result = {31'd0, (A < B)};
`endif
            default: w_result = 32'd0;
        endcase
    end

    // Output register; synchronous reset discards the operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_result;
            r_carry  <= w_carry;
            r_ovf    <= w_ovf;
            r_zero   <= (w_result == 32'd0);
        end
    end

    assign result   = r_result;
    assign carryout = r_carry;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with literal expectations,
// then randomized operations checked against a behavioural model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic [4:0]  shamt;
    logic [4:0]  opcode;
    logic [31:0] result;
    logic        carryout;
    logic        overflow;
    logic        zero;

    int n_tests;
    int n_fail;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .cin      (cin),
        .shamt    (shamt),
        .opcode   (opcode),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare packed {result, carryout, overflow, zero}
    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got r=%08h c=%0b v=%0b z=%0b, expected r=%08h c=%0b v=%0b z=%0b",
                     tag, got[34:3], got[2], got[1], got[0],
                     exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Reference model straight from the operation definitions
    function automatic logic [34:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci,
                                          input logic [4:0] sh);
        logic [31:0] r;
        logic        c;
        logic        v;
        longint unsigned s;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            5'd0: begin
                s = longint'(a) + longint'(b) + longint'(ci);
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = a << sh;
            5'd6: r = a >> sh;
            5'd7: begin
                r = a;
                for (int i = 0; i < int'(sh); i++) r = {a[31], r[31:1]};
            end
            5'd8: begin
                r = a;
                for (int i = 0; i < int'(sh); i++) r = {r[30:0], r[31]};
            end
            5'd9: begin
                r = a;
                for (int i = 0; i < int'(sh); i++) r = {r[0], r[31:1]};
            end
            5'd10: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SLTU_EN
            5'd11: r = (a < b) ? 32'd1 : 32'd0;
`endif
            default: r = 32'd0;
        endcase
        return {r, c, v, (r == 32'd0)};
    endfunction

    // Present one operation, then sample one edge later
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [4:0] sh);
        opcode = op;
        A      = a;
        B      = b;
        cin    = ci;
        shamt  = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic ci, input logic [4:0] sh,
                            input logic [31:0] er, input logic ec, input logic ev);
        run_op(op, a, b, ci, sh);
        check(tag, {result, carryout, overflow, zero}, {er, ec, ev, (er == 32'd0)});
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [4:0]  sh;
        logic [34:0] held;
        n_tests = 0;
        n_fail  = 0;

        // Reset while presenting ADD 15+10
        rst = 1'b1;
        run_op(5'd0, 32'd15, 32'd10, 1'b0, 5'd0);
        check("reset", {result, carryout, overflow, zero}, {32'd0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        directed("add_after_reset", 5'd0, 32'd15, 32'd10, 1'b0, 5'd0, 32'd25, 1'b0, 1'b0);

        directed("add_wrap",   5'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        directed("add_ovf",    5'd0, 32'h40000000, 32'h40000000, 1'b0, 5'd0, 32'h80000000, 1'b0, 1'b1);
        directed("add_cin",    5'd0, 32'h7, 32'h8, 1'b1, 5'd3, 32'h10, 1'b0, 1'b0);
        directed("sub_basic",  5'd1, 32'd20, 32'd5, 1'b0, 5'd0, 32'd15, 1'b1, 1'b0);
        directed("sub_ovf",    5'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h80000000, 1'b0, 1'b1);
        directed("sra",        5'd7, 32'h80000000, 32'h0, 1'b0, 5'd4, 32'hF8000000, 1'b0, 1'b0);
        directed("sll",        5'd5, 32'h0000FFFF, 32'h0, 1'b0, 5'd8, 32'h00FFFF00, 1'b0, 1'b0);
        directed("rotl",       5'd8, 32'h12345678, 32'h0, 1'b0, 5'd8, 32'h34567812, 1'b0, 1'b0);
        directed("rotr",       5'd9, 32'h12345678, 32'h0, 1'b0, 5'd8, 32'h78123456, 1'b0, 1'b0);
        directed("rotl_zero",  5'd8, 32'h12345678, 32'hFFFF, 1'b0, 5'd0, 32'h12345678, 1'b0, 1'b0);
        directed("srl",        5'd6, 32'h80000000, 32'h0, 1'b0, 5'd31, 32'h1, 1'b0, 1'b0);
        directed("slt",        5'd10, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0);
        directed("slt_false",  5'd10, 32'h1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        directed("and",        5'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 5'd0, 32'h05050505, 1'b0, 1'b0);
        directed("or",         5'd3, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 5'd0, 32'hAFAFAFAF, 1'b0, 1'b0);
        directed("xor",        5'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 5'd0, 32'hAAAAAAAA, 1'b0, 1'b0);
        directed("unused_20",  5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd3, 32'h0, 1'b0, 1'b0);
`ifdef ALU_SLTU_EN
        directed("sltu",       5'd11, 32'h1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0);
`else
        directed("op11_unused", 5'd11, 32'h1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
`endif

        // Output holds between edges even when inputs change
        held = {result, carryout, overflow, zero};
        A = 32'h0; B = 32'h0; opcode = 5'd0;
        #3;
        check("hold", {result, carryout, overflow, zero}, held);
        @(negedge clk);

        // Reset mid-stream discards the presented operation
        rst = 1'b1;
        run_op(5'd0, 32'd15, 32'd10, 1'b0, 5'd0);
        check("reset_mid", {result, carryout, overflow, zero}, {32'd0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        directed("add_after_reset2", 5'd0, 32'd15, 32'd10, 1'b0, 5'd0, 32'd25, 1'b0, 1'b0);

        // Randomized back-to-back operations
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
            case ($urandom_range(0, 4))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'h7FFFFFFF;
                1:       b = a;
                default: b = $urandom;
            endcase
            ci = 1'($urandom_range(0, 1));
            sh = 5'($urandom_range(0, 31));
            run_op(op, a, b, ci, sh);
            check($sformatf("rand_op%0d", op), {result, carryout, overflow, zero},
                  model(op, a, b, ci, sh));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
32-bit integer ALU for the datapath execute stage. Supports add with carry-in, subtract, bitwise logic, shifts, rotates and signed set-less-than. Operands are sampled on every rising clock edge. Result and status flags are registered, so they are valid one cycle after the operands are presented.

Parameters:
None. Data width is fixed at 32 bits; shift amount is 5 bits; opcode is 5 bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
A  input  32  operand A
B  input  32  operand B
cin  input  1  carry-in, used by ADD only
shamt  input  5  shift/rotate amount
opcode  input  5  operation select
result  output  32  registered result
carryout  output  1  registered carry / no-borrow flag
overflow  output  1  registered signed-overflow flag
zero  output  1  registered flag, 1 when result == 0

Behaviour:
- Single combinational compute stage feeding one output register. Latency is exactly 1 cycle and a new operation can start every cycle. There is no handshake: every edge samples the current inputs.
- Reset: on a clk edge with rst=1, outputs become result=0, carryout=0, overflow=0, zero=1. Reset overrides any operation in the same cycle, and the operation presented during reset is discarded. The first valid output appears on the edge after rst deasserts.
- Opcodes and the value registered into result:
  - 0 ADD: {carryout,result} = A + B + cin, computed at 33 bits. overflow = (A31 & B31 & ~R31) | (~A31 & ~B31 & R31).
  - 1 SUB: 33-bit sum A + ~B + 1; cin is ignored. carryout = bit 32, i.e. 1 means no borrow (A >= B unsigned). overflow = (A31 & ~B31 & ~R31) | (~A31 & B31 & R31).
  - 2 AND: A & B.
  - 3 OR: A | B.
  - 4 XOR: A ^ B.
  - 5 SLL: A << shamt, zero fill.
  - 6 SRL: A >> shamt, zero fill.
  - 7 SRA: A >>> shamt, sign fill from A31.
  - 8 ROTL: A rotated left by shamt. shamt=0 returns A unchanged.
  - 9 ROTR: A rotated right by shamt. shamt=0 returns A unchanged.
  - 10 SLT: {31'b0, signed(A) < signed(B)}.
  - 11–31: result=0 (see Optional Feature for opcode 11).
- carryout and overflow are 0 for every opcode other than ADD and SUB.
- zero = (result == 0) for every opcode, including the unused ones (zero=1).
- B is ignored by the shift and rotate operations. shamt is ignored by the arithmetic, logic and SLT operations.

Optional Feature:
ALU_SLTU_EN
- Defined: opcode 11 = SLTU, result = {31'b0, A < B unsigned}. carryout=0, overflow=0, zero follows the result.
- Not defined: opcode 11 behaves as an unused opcode (result 0, zero 1, carryout 0, overflow 0).

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_ADD=0 … OP_SLT=10, OP_SLTU=11), the data width (32) and the shift-amount width (5).
- Sub-module alu_shifter: combinational barrel shifter covering SLL, SRL, SRA, ROTL and ROTR, selected by a 3-bit mode. Add/sub, logic, SLT, flag generation and the output register stay in alu.

Test Plan:
- Addition, unsigned wrap: ADD A=FFFFFFFF, B=00000001, cin=0 -> result 00000000, carryout 1, overflow 0, zero 1.
- Addition, signed overflow: ADD A=40000000, B=40000000 -> result 80000000, carryout 0, overflow 1, zero 0.
- Subtraction:
  - SUB 20−5 -> result 15, carryout 1, overflow 0.
  - SUB A=7FFFFFFF, B=FFFFFFFF, cin=1 -> result 80000000, carryout 0, overflow 1 (cin ignored).
- Shifts and rotates:
  - SRA 80000000 by 4 -> F8000000.
  - SLL 0000FFFF by 8 -> 00FFFF00.
  - ROTL 12345678 by 8 -> 34567812.
  - ROTR 12345678 by 8 -> 78123456.
  - ROTL by 0 -> unchanged.
- SLT and unused opcodes:
  - SLT A=FFFFFFFF, B=1 -> 00000001.
  - AND A5A5A5A5 & 0F0F0F0F -> 05050505.
  - opcode 20 -> result 0, zero 1.
  - Each output appears exactly one edge after its inputs, back-to-back every cycle.
- Reset: assert rst while driving ADD 15+10 -> outputs 0/0/0, zero 1 on that edge. After deassertion, the first ADD 15+10 yields result 25 one edge later.
